// File: rtl/ofdm_symbol_framer.sv
// ofdm_symbol_framer: strips the cyclic prefix from an aligned OFDM sample stream and frames
// SYMBOL_LEN-sample symbols for the FFT, bounded by the decoded symbol count or MAX_SYMBOLS.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   clear                  synchronous clear, same effect as reset
//   sof                    first sample of the first cyclic prefix (qualified by a beat)
//   i_tdata/i_tlast/i_tvalid/i_tready   input sample stream
//   num_symbols(_valid)    decoded frame length strobe
//   o_tdata/o_tlast/o_eof/o_tvalid/o_tready   output symbol stream
//   symbol_idx             0-based index of the symbol in flight
//   frame_active           high while in CP or BODY
//   truncated              one-cycle pulse after a frame aborts on i_tlast
module ofdm_symbol_framer #(
    parameter int WIDTH             = 32,
    parameter int SYMBOL_LEN        = 64,
    parameter int CYCLIC_PREFIX_LEN = 16,
    parameter int MAX_SYMBOLS       = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             sof,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    input  logic [7:0]       num_symbols,
    input  logic             num_symbols_valid,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_eof,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [7:0]       symbol_idx,
    output logic             frame_active,
    output logic             truncated
);
    localparam int CW = $clog2(SYMBOL_LEN > CYCLIC_PREFIX_LEN ? SYMBOL_LEN : CYCLIC_PREFIX_LEN);

    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] samp_cnt_q, samp_cnt_d;
    logic [7:0]    symbol_idx_q, symbol_idx_d, len_q, len_d;
    logic          len_valid_q, len_valid_d, rdy_q, rdy_d, truncated_q, truncated_d;
    logic          in_body, beat, eff_valid, last_sym, sym_end;
    logic [7:0]    eff_len;
    logic [8:0]    next_idx;

    // rdy_q keeps i_tready low for the first cycle after reset/clear; CP is only ever
    // reached after a beat, so rdy_q is already 1 there.
    assign in_body  = state_q == BODY;
    assign i_tready = in_body ? o_tready : rdy_q;
    assign beat     = i_tvalid & i_tready;

    // A strobe arriving on the final body beat already counts for that beat's decision.
    assign eff_valid = num_symbols_valid | len_valid_q;
    assign eff_len   = num_symbols_valid ? num_symbols : len_q;
    assign next_idx  = {1'b0, symbol_idx_q} + 9'd1;
    assign last_sym  = (eff_valid && next_idx >= {1'b0, eff_len}) || next_idx == 9'(MAX_SYMBOLS);
    assign sym_end   = samp_cnt_q == CW'(SYMBOL_LEN - 1);

    assign o_tvalid     = in_body & i_tvalid;
    assign o_tdata      = in_body ? i_tdata : '0;
    assign o_tlast      = in_body & (sym_end | i_tlast);
    assign o_eof        = in_body & ((sym_end & last_sym) | i_tlast);
    assign symbol_idx   = symbol_idx_q;
    assign frame_active = state_q != IDLE;
    assign truncated    = truncated_q;

    always_comb begin
        state_d      = state_q;
        samp_cnt_d   = samp_cnt_q;
        symbol_idx_d = symbol_idx_q;
        len_d        = len_q;
        len_valid_d  = len_valid_q;
        truncated_d  = 1'b0;
        rdy_d        = 1'b1;
        if (state_q != IDLE && num_symbols_valid) begin
            len_d       = num_symbols;
            len_valid_d = 1'b1;
        end
        case (state_q)
            IDLE: if (beat && sof) begin
                // The sof beat is CP sample 0.
                state_d      = CYCLIC_PREFIX_LEN == 1 ? BODY : CP;
                samp_cnt_d   = CYCLIC_PREFIX_LEN == 1 ? '0 : CW'(1);
                symbol_idx_d = '0;
                len_valid_d  = num_symbols_valid;
                len_d        = num_symbols_valid ? num_symbols : len_q;
            end
            CP: if (beat) begin
                if (i_tlast) begin
                    state_d     = IDLE;
                    truncated_d = 1'b1;
                end else if (samp_cnt_q == CW'(CYCLIC_PREFIX_LEN - 1)) begin
                    state_d    = BODY;
                    samp_cnt_d = '0;
                end else begin
                    samp_cnt_d = samp_cnt_q + 1'b1;
                end
            end
            BODY: if (beat) begin
                if (i_tlast) begin
                    state_d     = IDLE;
                    truncated_d = 1'b1;
                end else if (sym_end) begin
                    samp_cnt_d = '0;
                    if (last_sym) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = CP;
                        symbol_idx_d = symbol_idx_q + 8'(symbol_idx_q != 8'(MAX_SYMBOLS - 1));
                    end
                end else begin
                    samp_cnt_d = samp_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d      = IDLE;
            samp_cnt_d   = '0;
            symbol_idx_d = '0;
            len_d        = '0;
            len_valid_d  = 1'b0;
            truncated_d  = 1'b0;
            rdy_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            samp_cnt_q   <= '0;
            symbol_idx_q <= '0;
            len_q        <= '0;
            len_valid_q  <= 1'b0;
            truncated_q  <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            samp_cnt_q   <= samp_cnt_d;
            symbol_idx_q <= symbol_idx_d;
            len_q        <= len_d;
            len_valid_q  <= len_valid_d;
            truncated_q  <= truncated_d;
            rdy_q        <= rdy_d;
        end
    end
endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// tb_ofdm_symbol_framer: randomized and directed stimulus against a frame-position model.
module tb_ofdm_symbol_framer;
    localparam int W = 32, SL = 64, CPL = 16, MX = 4, P = SL + CPL;

    logic clk = 0, resetn = 0, clear = 0, sof = 0, i_tlast = 0, i_tvalid = 0;
    logic o_tready = 0, num_symbols_valid = 0;
    logic [W-1:0] i_tdata = '0;
    logic [7:0] num_symbols = '0;
    logic i_tready, o_tlast, o_eof, o_tvalid, frame_active, truncated;
    logic [W-1:0] o_tdata;
    logic [7:0] symbol_idx;

    ofdm_symbol_framer #(.WIDTH(W), .SYMBOL_LEN(SL), .CYCLIC_PREFIX_LEN(CPL), .MAX_SYMBOLS(MX)) dut (
        .clk(clk), .resetn(resetn), .clear(clear), .sof(sof), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .num_symbols(num_symbols),
        .num_symbols_valid(num_symbols_valid), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_eof(o_eof),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .symbol_idx(symbol_idx),
        .frame_active(frame_active), .truncated(truncated)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    // Model: a frame is a position counter of accepted beats since sof; symbol and CP/body
    // location follow from division by the symbol period.
    bit m_act, m_rdy, m_lv, m_tr;
    int m_pos, m_len;
    int r_n, r_first, r_last, r_eof_at, r_eof_n, r_tl_n, r_tr_n;

    always @(negedge clk) begin : chk_proc
        int sym, off, bi, l;
        bit body, lv, last, e_vld, e_rdy, e_tl, e_eof, bad, bt;
        if (!resetn) begin
            m_act = 0; m_rdy = 0; m_lv = 0; m_len = 0; m_pos = 0; m_tr = 0;
        end else begin
            sym   = m_pos / P;
            off   = m_pos % P;
            body  = m_act && off >= CPL;
            bi    = off - CPL;
            lv    = num_symbols_valid || m_lv;
            l     = num_symbols_valid ? int'(num_symbols) : m_len;
            last  = (lv && sym + 1 >= l) || sym + 1 == MX;
            e_vld = body && i_tvalid;
            e_rdy = body ? o_tready : (m_act || m_rdy);
            e_tl  = bi == SL - 1 || i_tlast;
            e_eof = (bi == SL - 1 && last) || i_tlast;
            bad = o_tvalid !== e_vld || i_tready !== e_rdy || frame_active !== m_act
                || truncated !== m_tr || (m_act && symbol_idx !== 8'(sym))
                || (e_vld && (o_tdata !== i_tdata || o_tlast !== e_tl || o_eof !== e_eof));
            n_cmp++;
            if (bad) begin
                n_bad++;
                $display("FAIL cycle @%0t: got vld=%b rdy=%b act=%b trunc=%b idx=%0d data=%h tlast=%b eof=%b; want vld=%b rdy=%b act=%b trunc=%b idx=%0d data=%h tlast=%b eof=%b",
                    $time, o_tvalid, i_tready, frame_active, truncated, symbol_idx, o_tdata, o_tlast, o_eof,
                    e_vld, e_rdy, m_act, m_tr, sym, i_tdata, e_tl, e_eof);
            end
            if (o_tvalid && o_tready) begin
                if (r_n == 0) r_first = int'(o_tdata[15:0]);
                r_last = int'(o_tdata[15:0]);
                if (o_eof) begin
                    if (r_eof_n == 0) r_eof_at = r_n;
                    r_eof_n++;
                end
                if (o_tlast) r_tl_n++;
                r_n++;
            end
            if (truncated) r_tr_n++;
            bt = i_tvalid && e_rdy;
            m_tr = 0;
            if (!m_act) begin
                if (bt && sof) begin
                    m_act = 1; m_pos = 1; m_lv = num_symbols_valid;
                    if (num_symbols_valid) m_len = num_symbols;
                end
            end else begin
                if (num_symbols_valid) begin m_lv = 1; m_len = num_symbols; end
                if (bt) begin
                    if (i_tlast) begin m_act = 0; m_tr = 1; end
                    else if (body && bi == SL - 1 && last) m_act = 0;
                    else m_pos++;
                end
            end
            m_rdy = 1;
            if (clear) begin m_act = 0; m_rdy = 0; m_lv = 0; m_len = 0; m_tr = 0; end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic clr_rec();
        r_n = 0; r_first = -1; r_last = -1; r_eof_at = -1; r_eof_n = 0; r_tl_n = 0; r_tr_n = 0;
    endtask

    // Feeds input samples numbered 0.. (low 16 bits of i_tdata) until n have been accepted.
    task automatic stream(input int n, input int sof_at, input int sof2_at, input int ns_at,
                          input int ns_val, input int tl_at, input int vld_pct, input int rdy_pct);
        int sidx = 0;
        bit b = 0;
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            if (b) sidx++;
            if (sidx >= n) break;
            i_tvalid          = $urandom_range(99) < vld_pct;
            o_tready          = $urandom_range(99) < rdy_pct;
            i_tdata           = {16'($urandom), 16'(sidx)};
            sof               = sidx == sof_at || sidx == sof2_at;
            i_tlast           = sidx == tl_at;
            num_symbols_valid = sidx == ns_at;
            num_symbols       = 8'(ns_val);
            @(negedge clk);
            b = i_tvalid && i_tready;
        end
        chk("stream_done", int'(sidx >= n), 1);
        i_tvalid = 0; sof = 0; i_tlast = 0; num_symbols_valid = 0; o_tready = 0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int sa, nsa, tla;
        clr_rec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", int'({o_tvalid, i_tready, frame_active, truncated, o_tlast, o_eof}), 0);
        chk("rst_idx", symbol_idx, 0);
        chk("rst_data", int'(o_tdata), 0);
        resetn = 1;
        @(posedge clk); #1;
        chk("idle_tready", i_tready, 1);

        clr_rec();
        stream(260, 10, -1, 15, 3, -1, 100, 100);
        settle();
        chk("len_beats", r_n, 192);
        chk("len_first", r_first, 26);
        chk("len_last", r_last, 249);
        chk("len_eof_at", r_eof_at, 191);
        chk("len_eof_n", r_eof_n, 1);
        chk("len_tlast_n", r_tl_n, 3);

        clr_rec();
        stream(260, 10, -1, 116, 1, -1, 100, 100);
        settle();
        chk("late_beats", r_n, 128);
        chk("late_eof_at", r_eof_at, 127);

        clr_rec();
        stream(260, 10, -1, 15, 3, -1, 100, 50);
        settle();
        chk("bp_beats", r_n, 192);
        chk("bp_first", r_first, 26);
        chk("bp_last", r_last, 249);
        chk("bp_eof_at", r_eof_at, 191);

        clr_rec();
        stream(260, 10, -1, 15, 5, 216, 100, 100);
        settle();
        chk("trunc_beats", r_n, 159);
        chk("trunc_eof_at", r_eof_at, 158);
        chk("trunc_last", r_last, 216);
        chk("trunc_pulses", r_tr_n, 1);
        chk("trunc_tlast_n", r_tl_n, 3);

        clr_rec();
        stream(434, 10, 349, 349, 1, -1, 100, 100);
        settle();
        chk("cap_beats", r_n, 320);
        chk("cap_eof_at", r_eof_at, 255);
        chk("cap_eof_n", r_eof_n, 2);
        chk("cap_tlast_n", r_tl_n, 5);

        stream(66, 10, -1, -1, 0, -1, 100, 100);
        chk("pre_rst_active", frame_active, 1);
        resetn = 0;
        #1;
        chk("arst_flags", int'({o_tvalid, i_tready, frame_active, truncated, o_tlast, o_eof}), 0);
        chk("arst_idx", symbol_idx, 0);
        chk("arst_data", int'(o_tdata), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        clr_rec();
        stream(200, 3, -1, 3, 2, -1, 100, 100);
        settle();
        chk("post_rst_beats", r_n, 128);
        chk("post_rst_first", r_first, 19);
        chk("post_rst_last", r_last, 162);
        chk("post_rst_eof_at", r_eof_at, 127);

        stream(50, 5, -1, -1, 0, -1, 100, 100);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        chk("clr_active", frame_active, 0);
        chk("clr_tready", i_tready, 0);
        @(posedge clk); #1;
        chk("clr_tready_after", i_tready, 1);
        clr_rec();
        stream(100, 2, -1, 2, 1, -1, 100, 100);
        settle();
        chk("post_clr_beats", r_n, 64);
        chk("post_clr_first", r_first, 18);

        for (int k = 0; k < 8; k++) begin
            sa  = $urandom_range(8);
            nsa = $urandom_range(3) == 0 ? -1 : sa + $urandom_range(300);
            tla = $urandom_range(2) == 0 ? sa + $urandom_range(320) : -1;
            stream(sa + MX * P + 5, sa, -1, nsa, $urandom_range(5), tla, 70, 60);
            settle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
